// File: rtl/if_queue_if.sv
// Fetch-side and decode-side signals of the instruction-fetch queue.
// The queue uses the slave modport; the fetch/decode environment uses the master modport.
interface if_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_insn;
  logic              fetch_ready;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_insn;
  logic              if_en;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  fetch_valid, fetch_insn, stall, flush, new_pc, br_taken, br_addr,
    output fetch_pc, fetch_ready, if_pc, if_insn, if_en, count
  );

  modport master (
    output fetch_valid, fetch_insn, stall, flush, new_pc, br_taken, br_addr,
    input  fetch_pc, fetch_ready, if_pc, if_insn, if_en, count
  );
endinterface

// File: rtl/if_queue.sv
// Instruction-fetch queue: generates fetch addresses, buffers {pc, insn} pairs for decode.
// Define IF_QUEUE_BYPASS_EN to let an empty queue present the incoming fetch in the same cycle.
module if_queue #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 30,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_INSN = '0
) (
  input  logic        clk,
  input  logic        reset,
  if_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] insn;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              empty, redirect, push, pop, wr_en, byp;

  always_comb begin
    empty           = (count_q == '0);
    redirect        = bus.flush | bus.br_taken;
    bus.fetch_ready = (count_q != CNT_W'(DEPTH));
    push            = bus.fetch_valid & bus.fetch_ready & ~redirect;
`ifdef IF_QUEUE_BYPASS_EN
    byp             = empty & push;
`else
    byp             = 1'b0;
`endif
    pop             = ~empty & ~bus.stall & ~redirect;
    // A bypassed fetch consumed by decode this cycle never occupies an entry.
    wr_en           = push & ~(byp & ~bus.stall);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = bus.flush ? bus.new_pc : bus.br_addr;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push)  pc_d     = pc_q + ADDR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  always_comb begin
    bus.fetch_pc = pc_q;
    bus.count    = count_q;
    bus.if_en    = ~empty | byp;
    bus.if_pc    = empty ? pc_q     : mem_q[rd_ptr_q].pc;
    bus.if_insn  = empty ? NOP_INSN : mem_q[rd_ptr_q].insn;
    if (byp) bus.if_insn = bus.fetch_insn;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= RESET_PC;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{pc: pc_q, insn: bus.fetch_insn};
  end
endmodule

// File: tb/tb_if_queue.sv
// Randomized + directed bench for if_queue with a queue-based scoreboard model.
module tb_if_queue;
  localparam int           DW    = 32;
  localparam int           AW    = 30;
  localparam int           DEPTH = 4;
  localparam logic [AW-1:0] RPC  = 30'h10;
  localparam logic [DW-1:0] NOP  = 32'h13;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] insn;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  if_queue_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus();

  if_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(RPC), .NOP_INSN(NOP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  ent_t          sb[$];
  logic [AW-1:0] m_pc = RPC;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: compare against the model, then advance the model with the current inputs.
  logic m_redir, m_byp, m_push, m_pop;
  ent_t m_head;
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      m_pc = RPC;
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_if_en", 64'(bus.if_en), 64'd0);
      chk("rst_if_insn", 64'(bus.if_insn), 64'(NOP));
      chk("rst_fetch_pc", 64'(bus.fetch_pc), 64'(RPC));
    end else begin
      m_redir = bus.flush | bus.br_taken;
      m_byp   = 1'b0;
`ifdef IF_QUEUE_BYPASS_EN
      m_byp   = (sb.size() == 0) && bus.fetch_valid && !m_redir;
`endif
      chk("count", 64'(bus.count), 64'(sb.size()));
      chk("fetch_pc", 64'(bus.fetch_pc), 64'(m_pc));
      chk("fetch_ready", 64'(bus.fetch_ready), 64'(sb.size() != DEPTH));
      chk("if_en", 64'(bus.if_en), 64'((sb.size() != 0) || m_byp));
      if (sb.size() == 0 && !m_byp) begin
        chk("empty_if_insn", 64'(bus.if_insn), 64'(NOP));
        chk("empty_if_pc", 64'(bus.if_pc), 64'(m_pc));
      end else begin
        m_head = (sb.size() != 0) ? sb[0] : '{pc: m_pc, insn: bus.fetch_insn};
        chk("head_pc", 64'(bus.if_pc), 64'(m_head.pc));
        chk("head_insn", 64'(bus.if_insn), 64'(m_head.insn));
      end
      if (m_redir) begin
        sb.delete();
        m_pc = bus.flush ? bus.new_pc : bus.br_addr;
      end else begin
        m_push = bus.fetch_valid && (sb.size() != DEPTH);
        m_pop  = ((sb.size() != 0) || m_byp) && !bus.stall;
        if (m_pop && sb.size() != 0) void'(sb.pop_front());
        if (m_push) begin
          if (!(m_byp && !bus.stall)) sb.push_back('{pc: m_pc, insn: bus.fetch_insn});
          m_pc = m_pc + 1'b1;
        end
      end
    end
  end

  task automatic drv(input bit fv, input logic [DW-1:0] ins, input bit st,
                     input bit fl = 1'b0, input logic [AW-1:0] np = '0,
                     input bit bt = 1'b0, input logic [AW-1:0] ba = '0);
    bus.fetch_valid = fv;
    bus.fetch_insn  = ins;
    bus.stall       = st;
    bus.flush       = fl;
    bus.new_pc      = np;
    bus.br_taken    = bt;
    bus.br_addr     = ba;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.fetch_valid = 1'b0; bus.fetch_insn = '0; bus.stall = 1'b0;
    bus.flush = 1'b0; bus.new_pc = '0; bus.br_taken = 1'b0; bus.br_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Basic stream
    drv(1, 32'h11, 0); drv(1, 32'h22, 0); drv(1, 32'h33, 0);
    repeat (3) drv(0, '0, 0);

    // Fill to full under stall, fifth push ignored, then drain with wrap
    for (int i = 0; i < 5; i++) drv(1, 32'hA0 + i, 1);
    for (int i = 0; i < 8; i++) drv(1, 32'hB0 + i, 0);
    repeat (6) drv(0, '0, 0);

    // Flush beats branch; then branch alone
    for (int i = 0; i < 3; i++) drv(1, 32'hC0 + i, 1);
    drv(1, 32'hCF, 1, 1, 30'h100, 1, 30'h200);
    drv(0, '0, 1);
    drv(1, 32'hC8, 1); drv(1, 32'hC9, 1);
    drv(1, 32'hCA, 0, 0, '0, 1, 30'h300);
    repeat (2) drv(0, '0, 0);

    // Steady push+pop at count 2 across wrap
    drv(1, 32'hD0, 1); drv(1, 32'hD1, 1);
    for (int i = 0; i < 6; i++) drv(1, 32'hE0 + i, 0);
    repeat (4) drv(0, '0, 0);

    // fetch_pc wrap at the top of the address space
    drv(0, '0, 0, 1, 30'h3FFF_FFFE);
    for (int i = 0; i < 4; i++) drv(1, 32'h70 + i, 0);
    repeat (3) drv(0, '0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      drv($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
          $urandom_range(0, 30) == 0, AW'($urandom),
          $urandom_range(0, 25) == 0, AW'($urandom));
    repeat (6) drv(0, '0, 0);

    // Asynchronous reset between edges with count 3
    for (int i = 0; i < 3; i++) drv(1, 32'hF0 + i, 1);
    bus.fetch_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_count", 64'(bus.count), 64'd0);
    chk("async_rst_if_en", 64'(bus.if_en), 64'd0);
    chk("async_rst_if_insn", 64'(bus.if_insn), 64'(NOP));
    chk("async_rst_fetch_pc", 64'(bus.fetch_pc), 64'(RPC));
    @(posedge clk);
    #1 reset = 1'b1;
    drv(1, 32'h55, 1); drv(1, 32'h66, 0);
    repeat (4) drv(0, '0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
